// File: rtl/code_lock_pkg.sv
// Shared types and width helpers for the parameterised code lock.
// Pure declarations: no logic, no latency, no flow control.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    OPEN  = 2'd1,
    ALARM = 2'd2
  } state_t;

  // Index/count width for n distinct values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag; load wins over counting, stops at zero.
// One-cycle load latency; no backpressure.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/param_code_lock.sv
// Digit-entry code lock with open window, fail counting and alarm lockout.
// All outputs registered (one clock after the causing input); no backpressure, digits accepted every clock.
module param_code_lock
  import code_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 3,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 10,
  parameter int LOCKOUT_CYCLES = 20,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = (DIGITS*DIGIT_W)'(12'h688)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic                              digit_valid,
  input  logic                              abort,
  input  logic                              relock,
  input  logic                              code_wr,
  input  logic [DIGITS*DIGIT_W-1:0]         code_in,
  output logic [idx_w(DIGITS)-1:0]          sel,
  output logic                              locked,
  output logic                              alarm,
  output logic                              entimer,
  output logic                              err,
  output logic [idx_w(MAX_TRIES+1)-1:0]     tries_left
);

  localparam int SEL_W  = idx_w(DIGITS);
  localparam int TRY_W  = idx_w(MAX_TRIES + 1);
  localparam int TMR_W  = idx_w(max_of(UNLOCK_CYCLES, LOCKOUT_CYCLES));
  localparam int CODE_W = DIGITS * DIGIT_W;

  state_t             state, state_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic               mismatch, mis_n, mis_now;
  logic [TRY_W-1:0]   fails, fails_n;
  logic [CODE_W-1:0]  code, code_n;
  logic [DIGIT_W-1:0] exp_digit;
  logic               err_n;
  logic               t_load, t_done;
  logic [TMR_W-1:0]   t_val;

  assign exp_digit = code[idx*DIGIT_W +: DIGIT_W];
  assign sel       = idx;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    mis_n   = mismatch;
    fails_n = fails;
    code_n  = code;
    err_n   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    mis_now = mismatch | (digit != exp_digit);

    case (state)
      ENTRY: begin
        if (abort) begin
          idx_n = '0;
          mis_n = 1'b0;
        end else if (digit_valid) begin
          // A wrong digit only poisons the entry; the full length is always consumed.
          if (idx == SEL_W'(DIGITS - 1)) begin
            idx_n = '0;
            mis_n = 1'b0;
            if (!mis_now) begin
              state_n = OPEN;
              fails_n = '0;
              t_load  = 1'b1;
              t_val   = TMR_W'(UNLOCK_CYCLES - 1);
            end else begin
              fails_n = fails + TRY_W'(1);
              err_n   = 1'b1;
              if (fails_n == TRY_W'(MAX_TRIES)) begin
                state_n = ALARM;
                t_load  = 1'b1;
                t_val   = TMR_W'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            idx_n = idx + SEL_W'(1);
            mis_n = mis_now;
          end
        end
      end
      OPEN: begin
        if (code_wr)
          code_n = code_in;
        if (relock || t_done)
          state_n = ENTRY;
      end
      ALARM: begin
        if (t_done) begin
          state_n = ENTRY;
          fails_n = '0;
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ENTRY;
      idx        <= '0;
      mismatch   <= 1'b0;
      fails      <= '0;
      code       <= RESET_CODE;
      locked     <= 1'b1;
      alarm      <= 1'b0;
      entimer    <= 1'b0;
      err        <= 1'b0;
      tries_left <= TRY_W'(MAX_TRIES);
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      mismatch   <= mis_n;
      fails      <= fails_n;
      code       <= code_n;
      locked     <= (state_n != OPEN);
      alarm      <= (state_n == ALARM);
      entimer    <= (state_n == OPEN);
      err        <= err_n;
      tries_left <= TRY_W'(MAX_TRIES) - fails_n;
    end
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

endmodule
